hazard_unit: RTL and testbench

- Producer of the `stallSignal` consumed by the ID-stage control decoder in the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Keeps a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB) and detects RAW hazards against the instruction in ID.
- Drives the stall, PC/IF-ID write-enable and flush controls; applies flush on a taken branch resolved in MEM.
- Counts stall cycles for performance debug.

---
 rtl/hazard_unit_pkg.sv | 47 ++++
 rtl/hazard_unit_if.sv | 30 +++
 rtl/hazard_unit_decode.sv | 40 ++++
 rtl/hazard_unit.sv | 96 +++++++++
 tb/tb_hazard_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU-op encodings and the
// hazard scoreboard entry type.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Scoreboard slot order: youngest (EX) first.
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;
    localparam int SB_DEPTH = 3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  isLoad;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    typedef enum logic [1:0] {
        CLS_RTYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } op_class_t;

    // Unknown opcodes fall into the load row, same as the control decoder.
    function automatic op_class_t classifyOp(input logic [5:0] opCode);
        case (opCode)
            OP_RTYPE: return CLS_RTYPE;
            OP_SW:    return CLS_STORE;
            OP_BEQ:   return CLS_BRANCH;
            default:  return CLS_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage / hazard-unit signal bundle. master = pipeline side, slave = hazard unit.
interface hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);

    logic              idValid;
    logic [5:0]        idOpCode;
    logic [ADDR_W-1:0] idRs;
    logic [ADDR_W-1:0] idRt;
    logic [ADDR_W-1:0] idRd;
    logic              memBranchTaken;

    logic              stallSignal;
    logic              pcWrite;
    logic              ifIdWrite;
    logic              flush;
    logic [CNT_W-1:0]  stallCount;

    modport master (
        output idValid, idOpCode, idRs, idRt, idRd, memBranchTaken,
        input  stallSignal, pcWrite, ifIdWrite, flush, stallCount
    );

    modport slave (
        input  idValid, idOpCode, idRs, idRt, idRd, memBranchTaken,
        output stallSignal, pcWrite, ifIdWrite, flush, stallCount
    );

endinterface

// File: rtl/hazard_unit_decode.sv
// Opcode classifier: which register an instruction writes, whether it is a
// load, and whether rt is read as a source. Shared with the control decoder.
module hazard_decode
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [5:0]        opCode,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    output logic              hasDest,
    output logic [ADDR_W-1:0] dest,
    output logic              isLoad,
    output logic              usesRt
);

    always_comb begin
        dest   = '0;
        isLoad = 1'b0;
        usesRt = 1'b0;
        unique case (classifyOp(opCode))
            CLS_RTYPE: begin
                dest   = rd;
                usesRt = 1'b1;
            end
            CLS_STORE,
            CLS_BRANCH: begin
                usesRt = 1'b1;
            end
            CLS_LOAD: begin
                dest   = rt;
                isLoad = 1'b1;
            end
        endcase
    end

    // $0 is hardwired, so writing it produces nothing to wait for.
    assign hasDest = (dest != '0);

endmodule

// File: rtl/hazard_unit.sv
// RAW hazard detection and stall/flush control for the 5-stage MIPS pipeline.
// Define HAZARD_FORWARDING_EN when the EX/MEM forwarding network is present.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);

`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time.
    localparam logic [SB_DEPTH-1:0] STALL_STAGES = 3'b001;
    localparam logic                LOAD_ONLY    = 1'b1;
`else
    // WB is excluded: the register file writes in the first half-cycle.
    localparam logic [SB_DEPTH-1:0] STALL_STAGES = 3'b011;
    localparam logic                LOAD_ONLY    = 1'b0;
`endif

    sb_entry_t         sb [SB_DEPTH];
    sb_entry_t         idEntry;
    logic              idHasDest;
    logic [ADDR_W-1:0] idDest;
    logic              idIsLoad;
    logic              idUsesRt;
    logic              rawHazard;
    logic              stall;
    logic [CNT_W-1:0]  stallCnt;

    hazard_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .opCode  (hz.idOpCode),
        .rt      (hz.idRt),
        .rd      (hz.idRd),
        .hasDest (idHasDest),
        .dest    (idDest),
        .isLoad  (idIsLoad),
        .usesRt  (idUsesRt)
    );

    function automatic logic srcHit(input sb_entry_t e, input logic [ADDR_W-1:0] src);
        return e.valid && (src != '0) && (src == e.dest);
    endfunction

    always_comb begin
        rawHazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (STALL_STAGES[i] && (!LOAD_ONLY || sb[i].isLoad) &&
                (srcHit(sb[i], hz.idRs) || (idUsesRt && srcHit(sb[i], hz.idRt)))) begin
                rawHazard = 1'b1;
            end
        end
    end

    // A taken branch squashes the ID instruction anyway, so it overrides the stall.
    assign stall = hz.idValid && rawHazard && !hz.memBranchTaken;

    assign idEntry = '{valid: hz.idValid && idHasDest, dest: idDest, isLoad: idIsLoad};

    assign hz.stallSignal = stall;
    assign hz.pcWrite     = !stall;
    assign hz.ifIdWrite   = !stall;
    assign hz.flush       = hz.memBranchTaken;
    assign hz.stallCount  = stallCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb[i] <= SB_EMPTY;
            end
            stallCnt <= '0;
        end else begin
            sb[SB_WB] <= sb[SB_MEM];
            if (hz.memBranchTaken) begin
                sb[SB_MEM] <= SB_EMPTY;
                sb[SB_EX]  <= SB_EMPTY;
            end else if (stall) begin
                sb[SB_MEM] <= sb[SB_EX];
                sb[SB_EX]  <= SB_EMPTY;
            end else begin
                sb[SB_MEM] <= sb[SB_EX];
                sb[SB_EX]  <= idEntry;
            end

            if (stall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: cycle-by-cycle vector table plus hand
// sequences for branch flush, async reset mid-stall and counter saturation.
module tb_hazard_unit;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        stall;
        logic [15:0] cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   nCompared;
    int   nMismatched;
    vec_t tbl [$];

    hazard_unit_if #(.ADDR_W(5), .CNT_W(16)) hz ();
    hazard_unit_if #(.ADDR_W(5), .CNT_W(8))  hzs ();

    hazard_unit #(.ADDR_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    hazard_unit #(.ADDR_W(5), .CNT_W(8)) dutSat (
        .clk   (clk),
        .reset (reset),
        .hz    (hzs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic sNf, input logic sFw, input int cNf, input int cFw);
        vec_t r;
        r.v     = v;
        r.op    = op;
        r.rs    = rs;
        r.rt    = rt;
        r.rd    = rd;
        r.stall = FWD ? sFw : sNf;
        r.cnt   = 16'(FWD ? cFw : cNf);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic br);
        hz.idValid        = v;
        hz.idOpCode       = op;
        hz.idRs           = rs;
        hz.idRt           = rt;
        hz.idRd           = rd;
        hz.memBranchTaken = br;
    endtask

    task automatic chkOut(input string tag, input logic expStall, input logic expFlush,
                          input logic [15:0] expCnt);
        chk({tag, " stall"},     32'(hz.stallSignal), 32'(expStall));
        chk({tag, " pcWrite"},   32'(hz.pcWrite),     32'(!expStall));
        chk({tag, " ifIdWrite"}, 32'(hz.ifIdWrite),   32'(!expStall));
        chk({tag, " flush"},     32'(hz.flush),       32'(expFlush));
        chk({tag, " count"},     32'(hz.stallCount),  32'(expCnt));
    endtask

    initial begin
        logic [15:0] baseCnt;
        int          satStalls;

        nCompared   = 0;
        nMismatched = 0;

        //             v  op  rs  rt  rd  sNf sFw cNf cFw
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  0, 0));
        tbl.push_back(mk(1, 0,  1,  2,  3, 0, 0,  0, 0));   // add $3,$1,$2
        tbl.push_back(mk(1, 0,  3,  5,  4, 1, 0,  0, 0));   // add $4,$3,$5
        tbl.push_back(mk(1, 0,  3,  5,  4, 1, 0,  1, 0));
        tbl.push_back(mk(1, 0,  3,  5,  4, 0, 0,  2, 0));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  2, 0));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  2, 0));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  2, 0));
        tbl.push_back(mk(1, 35, 1,  5,  0, 0, 0,  2, 0));   // lw $5,0($1)
        tbl.push_back(mk(1, 0,  5,  2,  6, 1, 1,  2, 0));   // sub $6,$5,$2
        tbl.push_back(mk(1, 0,  5,  2,  6, 1, 0,  3, 1));
        tbl.push_back(mk(1, 0,  5,  2,  6, 0, 0,  4, 1));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  4, 1));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  4, 1));
        tbl.push_back(mk(1, 0,  1,  2,  0, 0, 0,  4, 1));   // add $0,$1,$2
        tbl.push_back(mk(1, 0,  0,  0,  4, 0, 0,  4, 1));   // add $4,$0,$0
        tbl.push_back(mk(1, 0,  1,  2,  9, 0, 0,  4, 1));   // add $9,$1,$2
        tbl.push_back(mk(1, 43, 1,  7,  0, 0, 0,  4, 1));   // sw $7,0($1)
        tbl.push_back(mk(1, 8,  1, 10,  0, 0, 0,  4, 1));   // opcode 8 -> load row, dest $10
        tbl.push_back(mk(1, 0, 10,  0, 11, 1, 1,  4, 1));   // add $11,$10,$0
        tbl.push_back(mk(1, 0, 10,  0, 11, 1, 0,  5, 2));
        tbl.push_back(mk(1, 0, 10,  0, 11, 0, 0,  6, 2));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  6, 2));
        tbl.push_back(mk(1, 0,  1,  2, 12, 0, 0,  6, 2));   // add $12,$1,$2
        tbl.push_back(mk(1, 35, 3, 12,  0, 0, 0,  6, 2));   // lw $12,0($3): rt is not a source
        tbl.push_back(mk(0, 0, 12, 12,  1, 0, 0,  6, 2));   // invalid ID never stalls
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  6, 2));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  6, 2));
        tbl.push_back(mk(1, 0,  1,  2, 16, 0, 0,  6, 2));   // add $16,$1,$2
        tbl.push_back(mk(1, 43, 2, 16,  0, 1, 0,  6, 2));   // sw $16,0($2)
        tbl.push_back(mk(1, 43, 2, 16,  0, 1, 0,  7, 2));
        tbl.push_back(mk(1, 43, 2, 16,  0, 0, 0,  8, 2));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  8, 2));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0,  8, 2));
        tbl.push_back(mk(1, 35, 1, 17,  0, 0, 0,  8, 2));   // lw $17,0($1)
        tbl.push_back(mk(1, 4,  1, 17,  0, 1, 1,  8, 2));   // beq $1,$17
        tbl.push_back(mk(1, 4,  1, 17,  0, 1, 0,  9, 3));
        tbl.push_back(mk(1, 4,  1, 17,  0, 0, 0, 10, 3));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 10, 3));
        tbl.push_back(mk(0, 0,  0,  0,  0, 0, 0, 10, 3));
        baseCnt = FWD ? 16'd3 : 16'd10;

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        hzs.idValid        = 1'b0;
        hzs.idOpCode       = 6'd0;
        hzs.idRs           = 5'd0;
        hzs.idRt           = 5'd0;
        hzs.idRd           = 5'd0;
        hzs.memBranchTaken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkOut("reset", 1'b0, 1'b0, 16'd0);
        chk("reset satCount", 32'(hzs.stallCount), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, 1'b0);
            #1;
            chkOut($sformatf("vec%0d", i), tbl[i].stall, 1'b0, tbl[i].cnt);
        end

        // Taken branch while a load-use is pending: EX and MEM must both be squashed.
        @(negedge clk); drive(1, 0, 1, 2, 18, 0);            // add $18,$1,$2
        @(negedge clk); drive(1, 35, 1, 8, 0, 0);            // lw $8,0($1)
        #1 chkOut("br lw", 1'b0, 1'b0, baseCnt);
        @(negedge clk); drive(1, 0, 8, 18, 13, 1);           // add $13,$8,$18 + branch
        #1 chkOut("br flush", 1'b0, 1'b1, baseCnt);
        @(negedge clk); drive(1, 0, 8, 18, 13, 0);
        #1 chkOut("br after", 1'b0, 1'b0, baseCnt);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0);
        #1 chkOut("br drain", 1'b0, 1'b0, baseCnt);

        // Asynchronous reset in the middle of a load-use stall.
        @(negedge clk); drive(1, 35, 1, 14, 0, 0);           // lw $14,0($1)
        @(negedge clk); drive(1, 0, 14, 0, 15, 0);           // add $15,$14,$0
        #1 chk("rst pre stall", 32'(hz.stallSignal), 32'd1);
        #1 reset = 1'b1;
        #1;
        chkOut("rst mid", 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1 hz.memBranchTaken = 1'b1;
        #1 chkOut("rst held br", 1'b0, 1'b1, 16'd0);
        hz.memBranchTaken = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 chkOut("rst release", 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        #1 chkOut("rst release2", 1'b0, 1'b0, 16'd0);

        // Saturation on the 8-bit instance: lw $5,0($5) held in ID stalls forever.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        hzs.idValid  = 1'b1;
        hzs.idOpCode = 6'd35;
        hzs.idRs     = 5'd5;
        hzs.idRt     = 5'd5;
        repeat (600) @(posedge clk);
        @(negedge clk);
        #1 chk("sat count", 32'(hzs.stallCount), 32'hFF);
        satStalls = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (hzs.stallSignal === 1'b1) satStalls++;
        end
        chk("sat stall cycles", 32'(satStalls), FWD ? 32'd3 : 32'd4);
        chk("sat no wrap", 32'(hzs.stallCount), 32'hFF);
        chk("main idle count", 32'(hz.stallCount), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
